// File: rtl/prog_mem_loader.sv
// Program memory with a chunked loader front-end and a single-cycle fetch port.
// The loader fills memory from address 0 upward, assembling LOAD_WIDTH chunks
// little-endian into DATA_WIDTH words. The CPU is held until a load completes.
//
// Handshake: a chunk transfers on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on state, never on
// load_valid. The source must hold load_data/load_last stable while
// load_valid is high and load_ready is low.
//
// state_dbg encoding: 0 = IDLE, 1 = LOAD, 2 = RUN.
module prog_mem_loader #(
    parameter int                    PC_WIDTH   = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 256,
    parameter int                    LOAD_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  fetch_req,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    output logic                  pc_fault,
    input  logic                  load_start,
    input  logic [LOAD_WIDTH-1:0] load_data,
    input  logic                  load_valid,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  cpu_hold,
    output logic [1:0]            state_dbg
);

    localparam int N  = DATA_WIDTH / LOAD_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]       CNT_MAX   = CW'(N - 1);
    localparam logic [PC_WIDTH-1:0] WADDR_MAX = PC_WIDTH'(DEPTH - 1);
    localparam logic [PC_WIDTH:0]   DEPTH_EXT = (PC_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   waddr_q, waddr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  pc_fault_q, pc_fault_d;
    logic                  load_done_q, load_done_d;

    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] word_asm;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Next-state, loader assembly and fetch decode
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
        pc_fault_d  = 1'b0;
        load_done_d = 1'b0;
        mem_we      = 1'b0;
        // Upper chunks of buf_q are always zero, so a short final word is
        // zero-filled without any extra masking.
        word_asm    = buf_q;
        word_asm[int'(cnt_q) * LOAD_WIDTH +: LOAD_WIDTH] = load_data;
        mem_wdata   = word_asm;

        if (load_start) begin
            // Restart wins over everything; any partial word is dropped.
            state_d = LOAD;
            waddr_d = '0;
            cnt_d   = '0;
            buf_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    if (load_valid) begin
                        if (cnt_q == CNT_MAX || load_last) begin
                            mem_we  = 1'b1;
                            buf_d   = '0;
                            cnt_d   = '0;
                            waddr_d = waddr_q + 1'b1;
                            if (load_last || waddr_q == WADDR_MAX) begin
                                state_d     = RUN;
                                load_done_d = 1'b1;
                            end
                        end else begin
                            buf_d = word_asm;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fetch_req) begin
                        ir_valid_d = 1'b1;
                        if ({1'b0, pc} < DEPTH_EXT) begin
                            ir_d = mem[pc];
                        end else begin
                            ir_d       = NOP_WORD;
                            pc_fault_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and output registers, asynchronously reset
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            pc_fault_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            pc_fault_q  <= pc_fault_d;
            load_done_q <= load_done_d;
        end
    end

    // Memory array: deliberately not reset so a reset keeps the program
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr_q] <= mem_wdata;
        end
    end

    assign ir         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign pc_fault   = pc_fault_q;
    assign load_done  = load_done_q;
    assign load_ready = (state_q == LOAD);
    assign cpu_hold   = (state_q != RUN);
    assign state_dbg  = state_q;

endmodule
